mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous data memory (1-cycle read latency) between two requesters: the CPU controller (C) and a DMA/IO engine (D).
- Arbitrates each cycle, muxes address, write data and write enable to the memory, and routes read data back with a valid strobe.
- Supports a bounded bus lock for atomic read-modify-write sequences.

Parameters:
- ADDR_W, 9, memory address width
- DATA_W, 9, data word width
- LOCK_MAX, 8, maximum cycles a lock may be held before forced release (≥2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- c_req  in  1  CPU access request; held with stable fields until c_gnt
- c_we  in  1  CPU write enable (1 = write, 0 = read)
- c_lock  in  1  CPU requests bus lock after this access
- c_addr  in  ADDR_W  CPU address
- c_wdata  in  DATA_W  CPU write data
- c_gnt  out  1  CPU access accepted this cycle (combinational)
- c_rvalid  out  1  CPU read data valid (registered)
- c_rdata  out  DATA_W  CPU read data
- d_req, d_we, d_lock, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: DMA equivalents, same widths and meanings
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read strobe
- arb_state  out  2  FSM state for debug: 0 IDLE, 1 LOCK_C, 2 LOCK_D

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; last_owner=D, so C wins the first conflict; lock_cnt=0; c_rvalid=d_rvalid=0.
  - While rst=1: c_gnt, d_gnt and mem_en are forced to 0.
  - A read granted in the cycle before rst rises produces no rvalid.
- Grant (combinational, same cycle as request):
  - At most one gnt per cycle.
  - mem_en = c_gnt | d_gnt.
  - mem_we, mem_addr and mem_wdata come from the winner; when no grant they are 0.
- IDLE:
  - Only one requester asserted: grant it.
  - Both asserted: grant the one that is not last_owner (round-robin).
  - last_owner updates to the winner on every grant.
- Lock entry: a granted access with lock=1 moves the FSM to LOCK_C or LOCK_D next cycle and clears lock_cnt.
- LOCK_X:
  - Only X may be granted; the other requester waits and its gnt stays 0.
  - lock_cnt increments every cycle.
  - A granted X access with lock=0 returns to IDLE next cycle.
  - When lock_cnt == LOCK_MAX-1, the FSM returns to IDLE next cycle regardless of X's lock input; a grant made in that cycle still completes.
  - Leaving lock, by either path, sets last_owner=X, so the waiting requester wins the next conflict.
  - X dropping req does not release the lock early; only the timeout does.
- Read return:
  - A granted read (we=0) sets the owner's rvalid for exactly the next cycle.
  - Both c_rdata and d_rdata = mem_rdata (pass-through); rvalid qualifies the data.
  - Back-to-back reads by alternating owners each return in order, one per cycle.
- Write: no rvalid is generated. Write data reaches memory in the grant cycle.
- Throughput: one access per cycle. No bubble on owner change or on lock entry/exit.

Optional Feature:
- Macro MEM_PORT_ARB_CPU_PRIO_EN.
- Defined: in IDLE, C always wins conflicts (fixed priority); last_owner is still tracked but ignored for arbitration. Lock rules are unchanged.
- Undefined: round-robin as described above.

Test Plan:
1. Reset, then c_req read addr 0x005 alone with mem returning 0x1A3 -> c_gnt=1 same cycle, mem_addr=0x005, mem_we=0; next cycle c_rvalid=1, c_rdata=0x1A3, d_rvalid=0.
2. Both req every cycle for 4 cycles after reset -> grant sequence C,D,C,D; each read's rvalid goes to the correct owner one cycle later.
3. d_req write 0x0FF to addr 0x010 with d_lock=1, then c_req held continuously, and D's next access has lock=0 -> c_gnt stays 0 while locked; arb_state=2; after D's unlocked access arb_state=0, and C is granted on the next cycle.
4. D locks and then drops req with c_req held, LOCK_MAX=8 -> arb_state=2 for exactly 8 cycles, then IDLE; c_gnt=1 on the first IDLE cycle.
5. rst asserted in the cycle after a granted C read -> c_rvalid=0; all gnt and mem_en are 0 during reset; arb_state=0 afterwards.
6. With MEM_PORT_ARB_CPU_PRIO_EN defined, both requesting for 3 cycles -> C,C,C granted; d_gnt=0 throughout.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous memory (1-cycle read latency) between
// a CPU requester (c_*) and a DMA/IO requester (d_*). One access is granted
// per cycle. A granted access may lock the bus for a bounded number of cycles
// so that read-modify-write sequences are atomic.
//
// Handshake: a requester raises *_req with stable we/lock/addr/wdata and holds
// it until the cycle in which *_gnt is high. *_gnt is combinational and the
// access takes place in that same cycle. A granted read raises *_rvalid for
// exactly the following cycle. *_rdata is the raw memory read data and is
// meaningful only while *_rvalid is high.
//
// Build option: define MEM_PORT_ARB_CPU_PRIO_EN to give the CPU fixed priority
// in IDLE conflicts. Without it, IDLE conflicts are resolved round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 9,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic              c_lock,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        arb_state
);

    localparam int CNT_W = $clog2(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_C = 2'd1,
        ST_LOCK_D = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    // 1 = DMA was the last owner, 0 = CPU was the last owner
    logic             last_d_q, last_d_d;
    logic             c_rvalid_q, d_rvalid_q;

    // State register plus read-return strobes; reset clears everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lock_cnt_q <= '0;
            last_d_q   <= 1'b1;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            last_d_q   <= last_d_d;
            c_rvalid_q <= c_gnt & ~c_we;
            d_rvalid_q <= d_gnt & ~d_we;
        end
    end

    // Next-state: lock entry on a locking grant, exit on unlocked grant or timeout
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        last_d_d   = last_d_q;
        if (c_gnt) last_d_d = 1'b0;
        if (d_gnt) last_d_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (c_gnt && c_lock) begin
                    state_d    = ST_LOCK_C;
                    lock_cnt_d = '0;
                end else if (d_gnt && d_lock) begin
                    state_d    = ST_LOCK_D;
                    lock_cnt_d = '0;
                end
            end
            ST_LOCK_C: begin
                lock_cnt_d = lock_cnt_q + CNT_W'(1);
                if ((lock_cnt_q == CNT_LAST) || (c_gnt && !c_lock)) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                    last_d_d   = 1'b0;
                end
            end
            ST_LOCK_D: begin
                lock_cnt_d = lock_cnt_q + CNT_W'(1);
                if ((lock_cnt_q == CNT_LAST) || (d_gnt && !d_lock)) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                    last_d_d   = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Outputs: grant selection and memory bus mux; all quiet during reset
    always_comb begin
        c_gnt     = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (c_req && d_req) begin
`ifdef MEM_PORT_ARB_CPU_PRIO_EN
                        c_gnt = 1'b1;
`else
                        c_gnt = last_d_q;
                        d_gnt = ~last_d_q;
`endif
                    end else begin
                        c_gnt = c_req;
                        d_gnt = d_req;
                    end
                end
                ST_LOCK_C: c_gnt = c_req;
                ST_LOCK_D: d_gnt = d_req;
                default: begin
                    c_gnt = 1'b0;
                    d_gnt = 1'b0;
                end
            endcase
        end
        if (c_gnt) begin
            mem_en    = 1'b1;
            mem_we    = c_we;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
        end else if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    // A read granted just before reset must not surface while reset is high
    assign c_rvalid  = c_rvalid_q & ~rst;
    assign d_rvalid  = d_rvalid_q & ~rst;
    assign c_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign arb_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the arbitration rules and
// a shadow copy of memory. Read returns go through expected queues that a
// separate monitor drains.
module tb_mem_port_arbiter;
  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 9;
  localparam int LOCK_MAX = 8;

  typedef struct {
    logic              v;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              c_req = 1'b0, c_we = 1'b0, c_lock = 1'b0;
  logic [ADDR_W-1:0] c_addr = '0;
  logic [DATA_W-1:0] c_wdata = '0;
  logic              d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [DATA_W-1:0] c_rdata, d_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [1:0]        arb_state;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .arb_state(arb_state)
  );

  // clock / memory
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem_arr [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] shadow  [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  // scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [DATA_W-1:0] c_exp_q[$];
  logic [DATA_W-1:0] d_exp_q[$];
  int c_tag_q[$];
  int d_tag_q[$];

  // reference model: 0 none / 1 CPU / 2 DMA
  int   m_owner = 0;
  int   m_left  = 0;
  int   m_last  = 2;
  txn_t pc, pd;
  logic rst_v = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // driver: one cycle with the current pending transactions
  task automatic step();
    int   win;
    txn_t t;
    bit   prio;
    @(posedge clk);
    #1;
    rst = rst_v;
    c_req = pc.v; c_we = pc.we; c_lock = pc.lock; c_addr = pc.addr; c_wdata = pc.wdata;
    d_req = pd.v; d_we = pd.we; d_lock = pd.lock; d_addr = pd.addr; d_wdata = pd.wdata;
    @(negedge clk);
    cyc++;
`ifdef MEM_PORT_ARB_CPU_PRIO_EN
    prio = 1'b1;
`else
    prio = 1'b0;
`endif
    win = 0;
    if (!rst_v) begin
      if (m_owner == 1)      win = pc.v ? 1 : 0;
      else if (m_owner == 2) win = pd.v ? 2 : 0;
      else if (pc.v && pd.v) win = prio ? 1 : ((m_last == 2) ? 1 : 2);
      else if (pc.v)         win = 1;
      else if (pd.v)         win = 2;
    end
    t = (win == 1) ? pc : pd;
    check("c_gnt", 32'(c_gnt), 32'(win == 1));
    check("d_gnt", 32'(d_gnt), 32'(win == 2));
    check("mem_en", 32'(mem_en), 32'(win != 0));
    check("mem_we", 32'(mem_we), (win != 0) ? 32'(t.we) : 32'd0);
    check("mem_addr", 32'(mem_addr), (win != 0) ? 32'(t.addr) : 32'd0);
    check("mem_wdata", 32'(mem_wdata), (win != 0) ? 32'(t.wdata) : 32'd0);
    check("arb_state", 32'(arb_state), 32'(m_owner));
    if (rst_v) begin
      m_owner = 0;
      m_left  = 0;
      m_last  = 2;
      c_exp_q.delete(); c_tag_q.delete();
      d_exp_q.delete(); d_tag_q.delete();
    end else begin
      if (win != 0) begin
        m_last = win;
        if (t.we) shadow[t.addr] = t.wdata;
        else if (win == 1) begin c_exp_q.push_back(shadow[t.addr]); c_tag_q.push_back(cyc + 1); end
        else begin d_exp_q.push_back(shadow[t.addr]); d_tag_q.push_back(cyc + 1); end
      end
      if (m_owner == 0) begin
        if (win != 0 && t.lock) begin
          m_owner = win;
          m_left  = LOCK_MAX;
        end
      end else begin
        m_left--;
        if (m_left == 0 || (win == m_owner && !t.lock)) m_owner = 0;
      end
      if (win == 1) pc.v = 1'b0;
      if (win == 2) pd.v = 1'b0;
    end
  endtask

  task automatic set_txn(output txn_t t, input logic we, input logic lock,
                         input int addr, input int wdata);
    t.v = 1'b1; t.we = we; t.lock = lock;
    t.addr = ADDR_W'(addr); t.wdata = DATA_W'(wdata);
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    step(); step();
    rst_v = 1'b0;
  endtask

  task automatic gen_random(inout txn_t t);
    if (!t.v && $urandom_range(0, 99) < 60) begin
      t.v     = 1'b1;
      t.we    = 1'($urandom_range(0, 1));
      t.lock  = ($urandom_range(0, 9) == 0);
      t.addr  = ADDR_W'($urandom_range(0, 15));
      t.wdata = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
    end
  endtask

  // monitor: compares every read return against the expected queues
  initial begin
    logic [DATA_W-1:0] e;
    bit exp_c, exp_d;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        check("rvalid_in_reset", {30'd0, c_rvalid, d_rvalid}, 32'd0);
      end else begin
        exp_c = (c_tag_q.size() > 0) && (c_tag_q[0] == cyc);
        exp_d = (d_tag_q.size() > 0) && (d_tag_q[0] == cyc);
        check("c_rvalid", 32'(c_rvalid), 32'(exp_c));
        check("d_rvalid", 32'(d_rvalid), 32'(exp_d));
        if (exp_c) begin
          e = c_exp_q.pop_front();
          void'(c_tag_q.pop_front());
          if (c_rvalid) check("c_rdata", 32'(c_rdata), 32'(e));
        end
        if (exp_d) begin
          e = d_exp_q.pop_front();
          void'(d_tag_q.pop_front());
          if (d_rvalid) check("d_rdata", 32'(d_rdata), 32'(e));
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [DATA_W-1:0] v;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      v = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      mem_arr[i] = v;
      shadow[i]  = v;
    end
    mem_arr[5] = 9'h1A3;
    shadow[5]  = 9'h1A3;
    pc = '{v: 1'b0, we: 1'b0, lock: 1'b0, addr: '0, wdata: '0};
    pd = pc;

    // single CPU read of 0x005 returning 0x1A3
    do_reset();
    set_txn(pc, 1'b0, 1'b0, 5, 0);
    step();
    step();

    // both requesting reads for four cycles: alternating owners
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (!pc.v) set_txn(pc, 1'b0, 1'b0, 16 + i, 0);
      if (!pd.v) set_txn(pd, 1'b0, 1'b0, 32 + i, 0);
      step();
    end
    pc.v = 1'b0; pd.v = 1'b0;
    step();

    // DMA locked write, CPU waits, DMA unlocked read releases the lock
    do_reset();
    set_txn(pd, 1'b1, 1'b1, 'h010, 'h0FF);
    set_txn(pc, 1'b0, 1'b0, 3, 0);
    step();
    step();
    set_txn(pd, 1'b0, 1'b0, 'h010, 0);
    step();
    step();
    step();

    // DMA locks then goes quiet: lock times out with CPU waiting
    do_reset();
    set_txn(pd, 1'b1, 1'b1, 'h020, 'h055);
    set_txn(pc, 1'b0, 1'b0, 'h020, 0);
    for (int i = 0; i < LOCK_MAX + 3; i++) step();

    // reset right after a granted CPU read
    do_reset();
    set_txn(pc, 1'b0, 1'b0, 5, 0);
    step();
    rst_v = 1'b1;
    set_txn(pc, 1'b0, 1'b0, 6, 0);
    set_txn(pd, 1'b0, 1'b0, 7, 0);
    step();
    step();
    rst_v = 1'b0;
    step();
    step();
    step();

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      gen_random(pc);
      gen_random(pd);
      rst_v = ($urandom_range(0, 299) == 0);
      step();
    end

    // drain and confirm no read return was lost
    rst_v = 1'b0;
    pc.v = 1'b0; pd.v = 1'b0;
    for (int i = 0; i < LOCK_MAX + 2; i++) step();
    check("c_queue_empty", 32'(c_exp_q.size()), 32'd0);
    check("d_queue_empty", 32'(d_exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
